sync_box: RTL and testbench

- Shared-memory arbiter and reservation checker for the dual-core DLX. It is the responder to each core's control unit.
- Each core presents a request, a VALIDATE trigger, a completion strobe, an atomic-instruction type and its MAR address.
- The block grants exclusive memory access through Pn_pass.
- It tracks one load-linked reservation per core and returns the store-conditional verdict on Pn_success.

---
 rtl/sync_box.sv | 159 +++++++++++++++
 tb/tb_sync_box.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_box.sv
// sync_box: round-robin memory ownership arbiter for two DLX cores with per-core LL/SC reservations.
// Grant and VALIDATE verdicts appear one cycle after the request/trigger; a core holds ownership until it completes, drops req or re-inits.
module sync_box #(
  parameter int ADR_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_P0,
  input  logic             trigger_P0,
  input  logic             P0_mem_complete,
  input  logic             atomic_inst_P0,
  input  logic [1:0]       instr_type_P0,
  input  logic             P0_mw,
  input  logic [ADR_W-1:0] P0_adr,
  input  logic             P0_in_init,
  input  logic             req_P1,
  input  logic             trigger_P1,
  input  logic             P1_mem_complete,
  input  logic             atomic_inst_P1,
  input  logic [1:0]       instr_type_P1,
  input  logic             P1_mw,
  input  logic [ADR_W-1:0] P1_adr,
  input  logic             P1_in_init,
  output logic             P0_pass,
  output logic             P0_success,
  output logic             P1_pass,
  output logic             P1_success,
  output logic [1:0]       owner
);

  // Encoding doubles as the debug owner code.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    OWN_P0 = 2'b01,
    OWN_P1 = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ptr;
  logic             w_ptr_nxt;
  logic [1:0]       r_succ;
  logic [1:0]       r_resv_vld;
  logic [ADR_W-1:0] r_resv_adr [2];

  logic [1:0]       w_req, w_init, w_trig, w_cmpl_in, w_mw;
  logic [1:0]       w_own, w_exit, w_cmpl, w_is_ll, w_is_sc, w_eval, w_wr;
  logic [1:0]       w_typ [2];
  logic [ADR_W-1:0] w_adr [2];
  logic [1:0]       w_resv_vld_nxt;
  logic [ADR_W-1:0] w_resv_adr_nxt [2];
  logic [ADR_W-1:0] w_wadr;
  logic             w_unused_atomic;

  assign w_req     = {req_P1, req_P0};
  assign w_init    = {P1_in_init, P0_in_init};
  assign w_trig    = {trigger_P1, trigger_P0};
  assign w_cmpl_in = {P1_mem_complete, P0_mem_complete};
  assign w_mw      = {P1_mw, P0_mw};
  assign w_typ[0]  = instr_type_P0;
  assign w_typ[1]  = instr_type_P1;
  assign w_adr[0]  = P0_adr;
  assign w_adr[1]  = P1_adr;
  assign w_own     = {r_state == OWN_P1, r_state == OWN_P0};
  assign w_unused_atomic = atomic_inst_P0 ^ atomic_inst_P1;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_exit[i]  = w_cmpl_in[i] | ~w_req[i] | w_init[i];
      w_cmpl[i]  = w_own[i] & w_cmpl_in[i];
      w_is_ll[i] = (w_typ[i] == 2'b01);
      w_is_sc[i] = (w_typ[i] == 2'b10);
      w_eval[i]  = w_is_sc[i] ? (r_resv_vld[i] && (r_resv_adr[i] == w_adr[i])) : 1'b1;
      // A failed SC never reaches memory, so it must not kill reservations.
      w_wr[i]    = w_cmpl[i] & w_mw[i] & (~w_is_sc[i] | r_succ[i]);
    end
  end

  // Only one core can own memory, so at most one writer per cycle.
  assign w_wadr = w_wr[1] ? P1_adr : P0_adr;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_req[0] && !w_init[0] && (!(w_req[1] && !w_init[1]) || !r_ptr))
          w_state_nxt = OWN_P0;
        else if (w_req[1] && !w_init[1])
          w_state_nxt = OWN_P1;
      end
      OWN_P0: begin
        if (w_exit[0]) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = 1'b1;
        end
      end
      OWN_P1: begin
        if (w_exit[1]) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Later assignments take precedence: an in_init clear beats a same-edge LL set.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_resv_vld_nxt[i] = r_resv_vld[i];
      w_resv_adr_nxt[i] = r_resv_adr[i];
      if ((|w_wr) && r_resv_vld[i] && (r_resv_adr[i] == w_wadr))
        w_resv_vld_nxt[i] = 1'b0;
      if (w_cmpl[i] && w_is_ll[i]) begin
        w_resv_vld_nxt[i] = 1'b1;
        w_resv_adr_nxt[i] = w_adr[i];
      end
      if (w_cmpl[i] && w_is_sc[i])
        w_resv_vld_nxt[i] = 1'b0;
      if (w_init[i])
        w_resv_vld_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_succ     <= 2'b00;
      r_resv_vld <= 2'b00;
      for (int i = 0; i < 2; i++) r_resv_adr[i] <= '0;
    end else begin
      r_resv_vld <= w_resv_vld_nxt;
      for (int i = 0; i < 2; i++) begin
        r_resv_adr[i] <= w_resv_adr_nxt[i];
        if (w_own[i] && w_exit[i])
          r_succ[i] <= 1'b0;
        else if (w_own[i] && w_trig[i])
          r_succ[i] <= w_eval[i];
      end
    end
  end

  assign P0_pass    = w_own[0];
  assign P1_pass    = w_own[1];
  assign P0_success = r_succ[0];
  assign P1_success = r_succ[1];
  assign owner      = r_state;

endmodule

// File: tb/tb_sync_box.sv
// Directed bench for sync_box: arbitration, round-robin, LL/SC verdicts, reservation kills, init/abort and reset.
module tb_sync_box;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, trig, cmpl, mw, init, atom;
  logic [1:0]  ityp [2];
  logic [31:0] adr [2];
  wire  [1:0]  pass, succ, owner;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sync_box #(.ADR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_P0(req[0]), .trigger_P0(trig[0]), .P0_mem_complete(cmpl[0]),
    .atomic_inst_P0(atom[0]), .instr_type_P0(ityp[0]), .P0_mw(mw[0]),
    .P0_adr(adr[0]), .P0_in_init(init[0]),
    .req_P1(req[1]), .trigger_P1(trig[1]), .P1_mem_complete(cmpl[1]),
    .atomic_inst_P1(atom[1]), .instr_type_P1(ityp[1]), .P1_mw(mw[1]),
    .P1_adr(adr[1]), .P1_in_init(init[1]),
    .P0_pass(pass[0]), .P0_success(succ[0]),
    .P1_pass(pass[1]), .P1_success(succ[1]),
    .owner(owner)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_p0pass"}, 32'(pass[0]), 0);
    chk({tag, "_p1pass"}, 32'(pass[1]), 0);
    chk({tag, "_p0succ"}, 32'(succ[0]), 0);
    chk({tag, "_p1succ"}, 32'(succ[1]), 0);
    chk({tag, "_owner"},  32'(owner), 0);
  endtask

  // One complete grant for core c, starting from IDLE with the other core quiet.
  task automatic txn(input int c, input logic [1:0] t, input logic [31:0] a, input logic w,
                     input logic do_trig, input logic exp_s, input string tag);
    req[c] = 1'b1;
    tick;
    chk({tag, "_pass"}, 32'(pass[c]), 1);
    ityp[c] = t;
    adr[c]  = a;
    atom[c] = (t == 2'b01) || (t == 2'b10);
    if (do_trig) begin
      trig[c] = 1'b1;
      tick;
      trig[c] = 1'b0;
      chk({tag, "_succ"}, 32'(succ[c]), 32'(exp_s));
    end
    mw[c]   = w;
    cmpl[c] = 1'b1;
    req[c]  = 1'b0;
    tick;
    cmpl[c] = 1'b0;
    mw[c]   = 1'b0;
    chk({tag, "_end_pass"}, 32'(pass[c]), 0);
    chk({tag, "_end_succ"}, 32'(succ[c]), 0);
  endtask

  initial begin
    reset = 1'b1;
    req = '0; trig = '0; cmpl = '0; mw = '0; init = '0; atom = '0;
    ityp[0] = 2'b00; ityp[1] = 2'b00;
    adr[0] = '0; adr[1] = '0;
    tick; tick;
    chk_all_zero("reset");
    reset = 1'b0;

    // Single requester: grant one cycle after req, release one cycle after complete
    req[0] = 1'b1;
    tick;
    chk("arb_p0pass", 32'(pass[0]), 1);
    chk("arb_owner", 32'(owner), 1);
    tick; tick; tick;
    cmpl[0] = 1'b1; req[0] = 1'b0;
    tick;
    cmpl[0] = 1'b0;
    chk("arb_release", 32'(pass[0]), 0);
    chk("arb_release_owner", 32'(owner), 0);

    // Pointer now favours P1
    req = 2'b11;
    tick;
    chk("rr_p1_first", 32'(pass[1]), 1);
    chk("rr_p0_wait", 32'(pass[0]), 0);
    chk("rr_owner_p1", 32'(owner), 2);
    cmpl[1] = 1'b1; req[1] = 1'b0;
    tick;
    cmpl[1] = 1'b0;
    chk("rr_gap_owner", 32'(owner), 0);
    tick;
    chk("rr_p0_next", 32'(pass[0]), 1);
    cmpl[0] = 1'b1; req[0] = 1'b0;
    tick;
    cmpl[0] = 1'b0;

    // Contention from reset: P0 first, P1 two cycles after P0 completes
    reset = 1'b1;
    tick;
    reset = 1'b0;
    req = 2'b11;
    tick;
    chk("cont_p0_first", 32'(pass[0]), 1);
    chk("cont_p1_wait", 32'(pass[1]), 0);
    cmpl[0] = 1'b1; req[0] = 1'b0;
    tick;
    cmpl[0] = 1'b0;
    chk("cont_gap_p1", 32'(pass[1]), 0);
    tick;
    chk("cont_p1_granted", 32'(pass[1]), 1);
    cmpl[1] = 1'b1; req[1] = 1'b0;
    tick;
    cmpl[1] = 1'b0;

    // LL then SC with hold and re-evaluation
    txn(0, 2'b01, 32'h40, 1'b0, 1'b0, 1'b0, "ll0");
    req[0] = 1'b1;
    tick;
    ityp[0] = 2'b10; adr[0] = 32'h40; atom[0] = 1'b1; trig[0] = 1'b1;
    tick;
    trig[0] = 1'b0;
    chk("sc0_succ", 32'(succ[0]), 1);
    tick;
    chk("sc0_hold", 32'(succ[0]), 1);
    adr[0] = 32'h44; trig[0] = 1'b1;
    tick;
    chk("sc0_reeval_miss", 32'(succ[0]), 0);
    adr[0] = 32'h40;
    tick;
    trig[0] = 1'b0;
    chk("sc0_reeval_hit", 32'(succ[0]), 1);
    mw[0] = 1'b1; cmpl[0] = 1'b1; req[0] = 1'b0;
    tick;
    mw[0] = 1'b0; cmpl[0] = 1'b0;
    chk("sc0_clear_succ", 32'(succ[0]), 0);
    txn(0, 2'b10, 32'h40, 1'b1, 1'b1, 1'b0, "sc0_again");

    // Reservation kill by the other core's store, and a near miss
    txn(0, 2'b01, 32'h40, 1'b0, 1'b0, 1'b0, "kill_ll");
    txn(1, 2'b00, 32'h40, 1'b1, 1'b0, 1'b0, "kill_st");
    txn(0, 2'b10, 32'h40, 1'b1, 1'b1, 1'b0, "kill_sc");
    txn(0, 2'b01, 32'h40, 1'b0, 1'b0, 1'b0, "miss_ll");
    txn(1, 2'b00, 32'h44, 1'b1, 1'b0, 1'b0, "miss_st");
    txn(0, 2'b10, 32'h40, 1'b1, 1'b1, 1'b1, "miss_sc");
    txn(1, 2'b11, 32'h10, 1'b0, 1'b1, 1'b1, "reserved_plain");

    // in_init during a grant drops pass and kills the reservation
    txn(1, 2'b01, 32'h80, 1'b0, 1'b0, 1'b0, "init_ll");
    req[1] = 1'b1;
    tick;
    chk("init_p1_own", 32'(pass[1]), 1);
    init[1] = 1'b1;
    tick;
    init[1] = 1'b0; req[1] = 1'b0;
    chk("init_p1_drop", 32'(pass[1]), 0);
    chk("init_owner", 32'(owner), 0);
    txn(1, 2'b10, 32'h80, 1'b1, 1'b1, 1'b0, "init_sc");

    // Non-owner strobes are ignored
    req[0] = 1'b1;
    tick;
    ityp[1] = 2'b00; trig[1] = 1'b1; cmpl[1] = 1'b1; mw[1] = 1'b1;
    tick;
    trig[1] = 1'b0; cmpl[1] = 1'b0; mw[1] = 1'b0;
    chk("nonowner_succ", 32'(succ[1]), 0);
    chk("nonowner_p0_kept", 32'(pass[0]), 1);
    cmpl[0] = 1'b1; req[0] = 1'b0;
    tick;
    cmpl[0] = 1'b0;

    // A core in INIT is never granted
    req[1] = 1'b1; init[1] = 1'b1;
    tick;
    chk("init_block_pass", 32'(pass[1]), 0);
    chk("init_block_owner", 32'(owner), 0);
    req[1] = 1'b0; init[1] = 1'b0;
    tick;

    // LL completing together with in_init: the clear wins
    req[1] = 1'b1;
    tick;
    ityp[1] = 2'b01; adr[1] = 32'h90; atom[1] = 1'b1; cmpl[1] = 1'b1; init[1] = 1'b1; req[1] = 1'b0;
    tick;
    cmpl[1] = 1'b0; init[1] = 1'b0;
    txn(1, 2'b10, 32'h90, 1'b1, 1'b1, 1'b0, "llinit_sc");

    // Reset mid-grant
    txn(0, 2'b01, 32'h40, 1'b0, 1'b0, 1'b0, "rst_ll");
    req[0] = 1'b1;
    tick;
    ityp[0] = 2'b10; adr[0] = 32'h40; atom[0] = 1'b1; trig[0] = 1'b1;
    tick;
    trig[0] = 1'b0;
    chk("rst_pre_succ", 32'(succ[0]), 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk_all_zero("rst_mid");
    tick;
    chk("rst_regrant", 32'(pass[0]), 1);
    trig[0] = 1'b1;
    tick;
    trig[0] = 1'b0;
    chk("rst_sc_fail", 32'(succ[0]), 0);
    cmpl[0] = 1'b1; mw[0] = 1'b1; req[0] = 1'b0;
    tick;
    cmpl[0] = 1'b0; mw[0] = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
